// File: rtl/aap_decode_stage.sv
// Decode stage: accepts 16-bit instruction words on a divided tick, assembles
// one- or two-word instructions and presents them with a table-driven control word.
module aap_decode_stage #(
    parameter int DIV_COUNT = 217,
    parameter int OPC_W     = 6,
    parameter int CTRL_W    = 8
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [15:0]       fetch_data,
    input  logic              fetch_valid,
    output logic              fetch_ready,
    input  logic              tbl_we,
    input  logic [OPC_W-1:0]  tbl_addr,
    input  logic [CTRL_W-1:0] tbl_wdata,
    output logic              tick,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [31:0]       dec_instr,
    output logic              dec_long,
    output logic [OPC_W-1:0]  dec_opcode,
    output logic [2:0]        dec_rd,
    output logic [2:0]        dec_ra,
    output logic [2:0]        dec_rb,
    output logic [CTRL_W-1:0] dec_ctrl,
    output logic              dec_err
);

    localparam int DEPTH = 2 ** OPC_W;
    localparam int CNT_W = (DIV_COUNT > 0) ? $clog2(DIV_COUNT + 1) : 1;
    localparam logic [CNT_W-1:0] DIV_MAX = CNT_W'(DIV_COUNT);

    localparam logic [1:0] ST_W1   = 2'd0;
    localparam logic [1:0] ST_W2   = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [CNT_W-1:0]  div_cnt;
    logic [1:0]        state;
    logic [CTRL_W-1:0] dec_table [DEPTH];
    logic [15:0]       first_word;
    logic [CTRL_W-1:0] first_ctrl;
    logic              transfer;
    logic [OPC_W-1:0]  fetch_opcode;
    logic [CTRL_W-1:0] fetch_ctrl;

    function automatic logic [OPC_W-1:0] opcode_of(input logic [15:0] w);
        return OPC_W'(w[14:9]);
    endfunction

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_MAX) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

    // Gated by reset so DIV_COUNT=0 does not pulse tick while held in reset.
    assign tick         = ~reset & (div_cnt == DIV_MAX);
    assign fetch_ready  = tick & ((state == ST_W1) | (state == ST_W2));
    assign transfer     = fetch_valid & fetch_ready;
    assign fetch_opcode = opcode_of(fetch_data);
    assign fetch_ctrl   = dec_table[fetch_opcode];

    // Reads see the pre-write entry when a write hits the same address this cycle.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                dec_table[i] <= '0;
            end
        end else if (tbl_we) begin
            dec_table[tbl_addr] <= tbl_wdata;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state      <= ST_W1;
            first_word <= '0;
            first_ctrl <= '0;
            dec_valid  <= 1'b0;
            dec_instr  <= '0;
            dec_long   <= 1'b0;
            dec_err    <= 1'b0;
            dec_opcode <= '0;
            dec_rd     <= '0;
            dec_ra     <= '0;
            dec_rb     <= '0;
            dec_ctrl   <= '0;
        end else begin
            case (state)
                ST_W1: begin
                    if (transfer) begin
                        if (!fetch_data[15]) begin
                            dec_instr  <= {16'h0000, fetch_data};
                            dec_long   <= 1'b0;
                            dec_err    <= 1'b0;
                            dec_opcode <= fetch_opcode;
                            dec_rd     <= fetch_data[8:6];
                            dec_ra     <= fetch_data[5:3];
                            dec_rb     <= fetch_data[2:0];
                            dec_ctrl   <= fetch_ctrl;
                            dec_valid  <= 1'b1;
                            state      <= ST_HOLD;
                        end else begin
                            first_word <= fetch_data;
                            first_ctrl <= fetch_ctrl;
                            state      <= ST_W2;
                        end
                    end
                end
                ST_W2: begin
                    if (transfer) begin
                        dec_instr  <= {fetch_data, first_word};
                        dec_long   <= 1'b1;
                        dec_err    <= ~fetch_data[15];
                        dec_opcode <= opcode_of(first_word);
                        dec_rd     <= first_word[8:6];
                        dec_ra     <= first_word[5:3];
                        dec_rb     <= first_word[2:0];
                        dec_ctrl   <= first_ctrl;
                        dec_valid  <= 1'b1;
                        state      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (dec_ready) begin
                        dec_valid <= 1'b0;
                        state     <= ST_W1;
                    end
                end
                default: begin
                    state <= ST_W1;
                end
            endcase
        end
    end

endmodule
